// File: rtl/rom_pkg.sv
// rom_pkg
// Shared constants for the 32x8 writable lookup store.
// DEFAULT_DATA_W : word width used when the top is instantiated without overrides
// DEFAULT_ADDR_W : address width used when the top is instantiated without overrides
// DEFAULT_DEPTH  : number of words implied by DEFAULT_ADDR_W
package rom_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DEPTH  = 2 ** DEFAULT_ADDR_W;

endpackage : rom_pkg

// File: rtl/rom_32x8.sv
// rom_32x8
// Small flip-flop based word store with per-word load and clear, and a
// registered read port that shows the post-edge content of the addressed word.
//
// Ports:
//   clk   : single clock, all state changes on its rising edge
//   rst   : asynchronous active-high reset; zeroes every word, LED and Ao
//   D     : write data, used only when Load=1 and Clear=0
//   A     : word address shared by write, clear and read
//   Clear : zero the word at A (wins over Load)
//   Load  : write D into the word at A
//   LED   : registered read data of the word addressed on the last edge
//   Ao    : registered copy of the address that LED belongs to
module rom_32x8
    import rom_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] D,
    input  logic [ADDR_W-1:0] A,
    input  logic              Clear,
    input  logic              Load,
    output logic [DATA_W-1:0] LED,
    output logic [ADDR_W-1:0] Ao
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage is kept in flops so that reset can wipe every word at once.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wrEn;
    logic [DATA_W-1:0] wrData;
    logic [DATA_W-1:0] readData;

    // Decide what, if anything, gets written this cycle. Clear is checked
    // first so it overrides Load, and D only matters for a plain Load.
    // The read value is taken write-first so LED reflects the word as it
    // will be after this edge rather than the stale content.
    always_comb begin
        wrEn     = 1'b0;
        wrData   = '0;
        readData = '0;
        if (Clear) begin
            wrEn   = 1'b1;
            wrData = '0;
        end else if (Load) begin
            wrEn   = 1'b1;
            wrData = D;
        end
        readData = wrEn ? wrData : mem[A];
    end

    // Storage array update. Reset is asynchronous so any write that was
    // set up for the current cycle is simply lost when rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wrEn) begin
            mem[A] <= wrData;
        end
    end

    // Registered read port: data and its address move together so a
    // consumer can always tell which word LED is showing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LED <= '0;
            Ao  <= '0;
        end else begin
            LED <= readData;
            Ao  <= A;
        end
    end

endmodule : rom_32x8

// File: tb/tb_rom_32x8.sv
// tb_rom_32x8
// Directed bench for rom_32x8. Each issued vector pushes its hand-computed
// LED/Ao pair into a queue; a monitor pops one entry per clock after the edge
// that should have produced it and compares against the DUT outputs.
module tb_rom_32x8;

    logic       clk;
    logic       rst;
    logic [7:0] D;
    logic [4:0] A;
    logic       Clear;
    logic       Load;
    logic [7:0] LED;
    logic [4:0] Ao;

    typedef struct {
        logic [7:0] led;
        logic [4:0] ao;
        string      name;
    } expect_t;

    expect_t expQ[$];

    int checkCount = 0;
    int errorCount = 0;

    rom_32x8 dut (
        .clk   (clk),
        .rst   (rst),
        .D     (D),
        .A     (A),
        .Clear (Clear),
        .Load  (Load),
        .LED   (LED),
        .Ao    (Ao)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point shared by the monitor and the direct reset checks.
    task automatic checkOutput(input string name, input logic [7:0] actLed,
                               input logic [4:0] actAo, input logic [7:0] expLed,
                               input logic [4:0] expAo);
        checkCount++;
        if (actLed !== expLed || actAo !== expAo) begin
            errorCount++;
            $display("[TB] FAIL %s: got LED=%h Ao=%0d, expected LED=%h Ao=%0d",
                     name, actLed, actAo, expLed, expAo);
        end
    endtask

    // Drive one vector on the falling edge and queue what the next rising
    // edge must produce.
    task automatic applyStimulus(input logic [4:0] addr, input logic [7:0] data,
                                 input logic ld, input logic clr,
                                 input logic [7:0] expLed, input string name);
        expect_t e;
        @(negedge clk);
        A     = addr;
        D     = data;
        Load  = ld;
        Clear = clr;
        e.led  = expLed;
        e.ao   = addr;
        e.name = name;
        expQ.push_back(e);
    endtask

    // Monitor: the DUT presents a new result every rising edge, so one queued
    // expectation is consumed shortly after each edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.name, LED, Ao, e.led, e.ao);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        D     = 8'h00;
        A     = 5'd0;
        Load  = 1'b0;
        Clear = 1'b0;

        // Reset value is visible before any clock edge.
        #1;
        checkOutput("resetInitial", LED, Ao, 8'h00, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Every word reads zero after reset; D is junk and must be ignored.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(5'(i), 8'hA5, 1'b0, 1'b0, 8'h00, $sformatf("sweep%0d", i));
        end

        // Basic loads, clear with priority over retained neighbour, reload.
        applyStimulus(5'd1, 8'h66, 1'b1, 1'b0, 8'h66, "loadA1");
        applyStimulus(5'd2, 8'hC3, 1'b1, 1'b0, 8'hC3, "loadA2");
        applyStimulus(5'd1, 8'h60, 1'b0, 1'b1, 8'h00, "clearA1");
        applyStimulus(5'd2, 8'h00, 1'b0, 1'b0, 8'hC3, "retainA2");
        applyStimulus(5'd1, 8'h7E, 1'b1, 1'b0, 8'h7E, "reloadA1");
        applyStimulus(5'd1, 8'h00, 1'b0, 1'b0, 8'h7E, "readA1");

        // Clear beats Load on the same edge.
        applyStimulus(5'd5, 8'h3C, 1'b1, 1'b0, 8'h3C, "loadA5");
        applyStimulus(5'd5, 8'hFF, 1'b1, 1'b1, 8'h00, "loadClearA5");
        applyStimulus(5'd5, 8'h12, 1'b0, 1'b0, 8'h00, "readA5");

        // Boundary address and a read-back of an unrelated word.
        applyStimulus(5'd31, 8'h81, 1'b1, 1'b0, 8'h81, "loadA31");
        applyStimulus(5'd0,  8'h00, 1'b0, 1'b0, 8'h00, "readA0");
        applyStimulus(5'd31, 8'h00, 1'b0, 1'b0, 8'h81, "readA31");
        applyStimulus(5'd2,  8'h00, 1'b0, 1'b0, 8'hC3, "readA2again");

        // Load A=3, then assert reset between edges: outputs drop at once.
        applyStimulus(5'd3, 8'hAA, 1'b1, 1'b0, 8'hAA, "loadA3");
        @(posedge clk);
        #3;
        rst  = 1'b1;
        Load = 1'b0;
        #1;
        checkOutput("rstAsync", LED, Ao, 8'h00, 5'd0);
        @(negedge clk);
        rst = 1'b0;

        // A write set up for a cycle in which reset rises is discarded, and
        // a Load seen at an edge during reset is ignored.
        @(negedge clk);
        A    = 5'd4;
        D    = 8'h55;
        Load = 1'b1;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("rstHoldLoad", LED, Ao, 8'h00, 5'd0);
        @(negedge clk);
        Load = 1'b0;
        rst  = 1'b0;

        applyStimulus(5'd3, 8'h00, 1'b0, 1'b0, 8'h00, "readA3afterRst");
        applyStimulus(5'd4, 8'h00, 1'b0, 1'b0, 8'h00, "readA4afterRst");
        applyStimulus(5'd1, 8'h00, 1'b0, 1'b0, 8'h00, "readA1afterRst");
        applyStimulus(5'd9, 8'h5A, 1'b1, 1'b0, 8'h5A, "loadA9afterRst");

        // Let the monitor drain, bounded so a stuck queue cannot hang the run.
        for (int n = 0; n < 10 && expQ.size() > 0; n++) begin
            @(posedge clk);
            #2;
        end
        checkCount++;
        if (expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_rom_32x8
